// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between the MEM stage and the data memory.
// Loads own the memory port when requested and are forwarded from the
// youngest matching buffered store; stores drain one per non-load cycle.
module store_buffer #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_fwd,
  output logic              empty,
  output logic              memwrite,
  output logic              memread,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_write_data,
  input  logic [DATA_W-1:0] memory_read_data
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;

  logic              push;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // A full buffer refuses stores even when a drain frees a slot this cycle.
  assign st_ready = (count != FULL);
  assign empty    = (count == '0);
  assign push     = st_valid && st_ready;
  assign drain    = !ld_valid && (count != '0);

  // Port arbitration: a load always wins, otherwise the head entry drains.
  assign memread           = rst_n && ld_valid;
  assign memwrite          = rst_n && drain;
  assign memory_address    = ld_valid ? ld_addr : ent_addr[head];
  assign memory_write_data = ent_data[head];

  // Youngest-match search: walk oldest to youngest so later hits override.
  // Only registered entries take part, so a store accepted on the load's
  // own edge is never seen by that load.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && (ent_addr[head + PTR_W'(i)] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[head + PTR_W'(i)];
      end
    end
  end

  // Entry storage; cleared on reset so the idle memory address/data read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

  // Pointers and occupancy; push and drain together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      unique case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Load return stage: result registered one cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_done <= 1'b0;
      ld_fwd  <= 1'b0;
      ld_data <= '0;
    end else begin
      ld_done <= ld_valid;
      ld_fwd  <= ld_valid && fwd_hit;
      if (ld_valid) ld_data <= fwd_hit ? fwd_data : memory_read_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus random traffic against a queue
// based reference model of the store buffer and its data memory.
module tb_store_buffer;

  localparam int DATA_W = 5;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_done;
  logic [DATA_W-1:0] ld_data;
  logic              ld_fwd;
  logic              empty;
  logic              memwrite;
  logic              memread;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] memory_write_data;
  logic [DATA_W-1:0] memory_read_data;

  store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .ld_valid          (ld_valid),
    .ld_addr           (ld_addr),
    .ld_done           (ld_done),
    .ld_data           (ld_data),
    .ld_fwd            (ld_fwd),
    .empty             (empty),
    .memwrite          (memwrite),
    .memread           (memread),
    .memory_address    (memory_address),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, clocked write.
  logic [DATA_W-1:0] dut_mem [32] = '{default: '0};
  assign memory_read_data = dut_mem[memory_address];
  always @(posedge clk) if (memwrite) dut_mem[memory_address] <= memory_write_data;

  // Reference model: in-order queue of pending stores and the memory image.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t              q[$];
  logic [DATA_W-1:0] ref_mem [32];
  logic              exp_done;
  logic [DATA_W-1:0] exp_data;
  logic              exp_fwd;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check everything against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic step(input logic sv, input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                      input logic lv, input logic [ADDR_W-1:0] la);
    logic              accept;
    logic              hit;
    logic [DATA_W-1:0] res;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    @(negedge clk);
    chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("memread",  32'(memread),  32'(lv));
    chk("memwrite", 32'(memwrite), 32'(!lv && q.size() > 0));
    if (lv) chk("load_addr", 32'(memory_address), 32'(la));
    else if (q.size() > 0) begin
      chk("drain_addr", 32'(memory_address),    32'(q[0].a));
      chk("drain_data", 32'(memory_write_data), 32'(q[0].d));
    end
    chk("ld_done", 32'(ld_done), 32'(exp_done));
    if (exp_done) begin
      chk("ld_data", 32'(ld_data), 32'(exp_data));
      chk("ld_fwd",  32'(ld_fwd),  32'(exp_fwd));
    end
    accept = sv && (q.size() < DEPTH);
    hit = 1'b0;
    res = ref_mem[la];
    foreach (q[i]) if (q[i].a == la) begin hit = 1'b1; res = q[i].d; end
    @(posedge clk);
    if (lv) begin exp_data = res; exp_fwd = hit; end
    exp_done = lv;
    if (!lv && q.size() > 0) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (accept) q.push_back('{a: sa, d: sd});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    exp_done = 1'b0; exp_data = '0; exp_fwd = 1'b0;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
    #1;
    chk("rst_ready",    32'(st_ready), 32'd1);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_ld_done",  32'(ld_done),  32'd0);
    chk("rst_ld_data",  32'(ld_data),  32'd0);
    chk("rst_mem_addr", 32'(memory_address), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill while loads hold the port, then drain in order.
    step(1'b1, 5'd1, 5'd7,  1'b1, 5'd31);
    step(1'b1, 5'd2, 5'd8,  1'b1, 5'd31);
    step(1'b1, 5'd3, 5'd9,  1'b1, 5'd31);
    step(1'b1, 5'd4, 5'd10, 1'b1, 5'd31);
    chk("full_ready", 32'(st_ready), 32'd0);
    step(1'b1, 5'd5, 5'd11, 1'b1, 5'd31);
    step(1'b1, 5'd5, 5'd11, 1'b0, 5'd0);
    step(1'b1, 5'd5, 5'd11, 1'b0, 5'd0);
    idle(5);
    chk("drained_empty", 32'(empty), 32'd1);

    // Forwarding picks the youngest of two matching entries.
    step(1'b1, 5'd5, 5'd3, 1'b1, 5'd31);
    step(1'b1, 5'd5, 5'd6, 1'b1, 5'd31);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5);
    chk("fwd_data", 32'(ld_data), 32'd6);
    chk("fwd_flag", 32'(ld_fwd),  32'd1);
    idle(3);

    // Load served from memory with the buffer empty.
    step(1'b1, 5'd11, 5'd6, 1'b0, 5'd0);
    idle(2);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd11);
    chk("mem_done", 32'(ld_done), 32'd1);
    chk("mem_data", 32'(ld_data), 32'd6);
    chk("mem_fwd",  32'(ld_fwd),  32'd0);
    idle(1);

    // Store accepted on the same edge as a load is not forwarded to it.
    step(1'b1, 5'd9, 5'd4, 1'b1, 5'd9);
    chk("same_edge_data", 32'(ld_data), 32'd0);
    chk("same_edge_fwd",  32'(ld_fwd),  32'd0);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd9);
    chk("next_load_data", 32'(ld_data), 32'd4);
    chk("next_load_fwd",  32'(ld_fwd),  32'd1);
    idle(2);

    // Load stream starves draining; both entries leave once it stops.
    step(1'b1, 5'd12, 5'd1, 1'b1, 5'd30);
    step(1'b1, 5'd13, 5'd2, 1'b1, 5'd30);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 5'd0, 1'b1, 5'd30);
    chk("starve_not_empty", 32'(empty), 32'd0);
    idle(2);
    chk("starve_drained", 32'(empty), 32'd1);

    // Reset asserted mid-drain with three entries buffered.
    step(1'b1, 5'd20, 5'd1, 1'b1, 5'd31);
    step(1'b1, 5'd21, 5'd2, 1'b1, 5'd31);
    step(1'b1, 5'd22, 5'd3, 1'b1, 5'd31);
    st_valid = 1'b0; ld_valid = 1'b0;
    #2;
    chk("pre_rst_memwrite", 32'(memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty",    32'(empty),    32'd1);
    chk("mid_rst_ready",    32'(st_ready), 32'd1);
    chk("mid_rst_memwrite", 32'(memwrite), 32'd0);
    ld_valid = 1'b1;
    #1;
    chk("mid_rst_memread",  32'(memread),  32'd0);
    ld_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_done = 1'b0;
    @(posedge clk); #1;
    idle(3);

    // Random traffic over a narrow address range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end
    idle(DEPTH + 1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
